serial_adder_subtractor: RTL and testbench

SERIAL_ADDER_SUBTRACTOR -- requirements
Module: serial_adder_subtractor

---
 rtl/serial_adder_subtractor.sv | 118 +++++++++++
 tb/tb_serial_adder_subtractor.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder_subtractor.sv
// Digit-serial adder/subtractor: one DIGIT-bit slice per clock, LSB slice first.
// The result and flags are registered once, when the last slice completes.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for in_start
// RUN   | adding one slice per cycle, N cycles total
// DONE  | result valid and ou_done high for one cycle; accepts new start
module serial_adder_subtractor #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_c,
  input  logic             in_en,
  output logic [WIDTH-1:0] ou_s,
  output logic             ou_c,
  output logic             ou_v,
  output logic             ou_z,
  output logic             ou_busy,
  output logic             ou_done
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if ((WIDTH < 2) || (DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
      $error("serial_adder_subtractor: WIDTH must be >= 2 and an integer multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_nxt;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             last;
  logic             accept;
  logic [DIGIT:0]   slice;
  logic             msb_cin;

  assign accept = (state != RUN) && in_start;
  assign last   = (cnt_q == CW'(N - 1));

  // a_q/b_q shift right each cycle, so the current slice always sits at the bottom
  assign slice   = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
  assign sum_nxt = (sum_q >> DIGIT) | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));
  // In the final slice the top operand bits are the MSBs; recover the carry into the MSB
  assign msb_cin = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ slice[DIGIT-1];

  always_ff @(posedge in_clk) begin
    if (in_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = in_start ? RUN : IDLE;
      RUN:     state_nxt = last ? DONE : RUN;
      DONE:    state_nxt = in_start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ou_busy = 1'b0;
    ou_done = 1'b0;
    case (state)
      RUN:     ou_busy = 1'b1;
      DONE:    ou_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      ou_s    <= '0;
      ou_c    <= 1'b0;
      ou_v    <= 1'b0;
      ou_z    <= 1'b0;
    end else if (accept) begin
      a_q     <= in_a;
      b_q     <= in_en ? ~in_b : in_b;
      carry_q <= in_c;
      sum_q   <= '0;
      cnt_q   <= '0;
    end else if (state == RUN) begin
      a_q     <= a_q >> DIGIT;
      b_q     <= b_q >> DIGIT;
      sum_q   <= sum_nxt;
      carry_q <= slice[DIGIT];
      cnt_q   <= cnt_q + CW'(1);
      if (last) begin
        ou_s <= sum_nxt;
        ou_c <= slice[DIGIT];
        ou_v <= msb_cin ^ slice[DIGIT];
        ou_z <= (sum_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_subtractor.sv
// Directed bench for serial_adder_subtractor: a 16/4 instance and an 8/1 instance
// sharing clock and reset, with hand-computed expected results.
module tb_serial_adder_subtractor;

  logic        clk;
  logic        rst;

  logic        start16, c16, en16;
  logic [15:0] a16, b16, s16;
  logic        co16, v16, z16, busy16, done16;

  logic        start8, c8, en8;
  logic [7:0]  a8, b8, s8;
  logic        co8, v8, z8, busy8, done8;

  int          n_vec;
  int          n_err;
  int          sel_g;
  logic [15:0] prev_s [2];

  logic [15:0] s_m;
  logic        c_m, v_m, z_m, busy_m, done_m;

  serial_adder_subtractor #(.WIDTH(16), .DIGIT(4)) dut16 (
    .in_clk(clk), .in_rst(rst), .in_start(start16), .in_a(a16), .in_b(b16),
    .in_c(c16), .in_en(en16), .ou_s(s16), .ou_c(co16), .ou_v(v16), .ou_z(z16),
    .ou_busy(busy16), .ou_done(done16)
  );

  serial_adder_subtractor #(.WIDTH(8), .DIGIT(1)) dut8 (
    .in_clk(clk), .in_rst(rst), .in_start(start8), .in_a(a8), .in_b(b8),
    .in_c(c8), .in_en(en8), .ou_s(s8), .ou_c(co8), .ou_v(v8), .ou_z(z8),
    .ou_busy(busy8), .ou_done(done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    s_m    = (sel_g != 0) ? {8'h00, s8} : s16;
    c_m    = (sel_g != 0) ? co8   : co16;
    v_m    = (sel_g != 0) ? v8    : v16;
    z_m    = (sel_g != 0) ? z8    : z16;
    busy_m = (sel_g != 0) ? busy8 : busy16;
    done_m = (sel_g != 0) ? done8 : done16;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic st, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic en);
    if (sel == 0) begin
      start16 = st; a16 = a; b16 = b; c16 = c; en16 = en;
    end else begin
      start8 = st; a8 = a[7:0]; b8 = b[7:0]; c8 = c; en8 = en;
    end
  endtask

  // Starts an operation in the current cycle and checks every cycle up to DONE.
  // glitch = k drives a conflicting start and new operands in RUN cycle k.
  task automatic run_op(input int sel, input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic en, input logic [15:0] es, input logic ec,
                        input logic ev, input logic ez, input int glitch);
    int n;
    n = (sel != 0) ? 8 : 4;
    sel_g = sel;
    drive(sel, 1'b1, a, b, c, en);
    @(posedge clk); #1;
    drive(sel, 1'b0, a, b, c, en);
    for (int k = 1; k <= n; k++) begin
      check({tag, "/busy"}, 32'(busy_m), 32'd1);
      check({tag, "/done_early"}, 32'(done_m), 32'd0);
      check({tag, "/s_held"}, 32'(s_m), 32'(prev_s[sel]));
      if (k == glitch) drive(sel, 1'b1, ~a, a, ~c, ~en);
      @(posedge clk); #1;
      drive(sel, 1'b0, ~a, a, ~c, ~en);
    end
    check({tag, "/done"}, 32'(done_m), 32'd1);
    check({tag, "/busy_off"}, 32'(busy_m), 32'd0);
    check({tag, "/s"}, 32'(s_m), 32'(es));
    check({tag, "/c"}, 32'(c_m), 32'(ec));
    check({tag, "/v"}, 32'(v_m), 32'(ev));
    check({tag, "/z"}, 32'(z_m), 32'(ez));
    prev_s[sel] = es;
  endtask

  task automatic idle_cycle(input int sel, input string tag);
    sel_g = sel;
    @(posedge clk); #1;
    check({tag, "/idle_done"}, 32'(done_m), 32'd0);
    check({tag, "/idle_busy"}, 32'(busy_m), 32'd0);
  endtask

  task automatic check_zero(input int sel, input string tag);
    sel_g = sel;
    check({tag, "/s"}, 32'(s_m), 32'd0);
    check({tag, "/c"}, 32'(c_m), 32'd0);
    check({tag, "/v"}, 32'(v_m), 32'd0);
    check({tag, "/z"}, 32'(z_m), 32'd0);
    check({tag, "/busy"}, 32'(busy_m), 32'd0);
    check({tag, "/done"}, 32'(done_m), 32'd0);
    prev_s[sel] = 16'h0000;
  endtask

  initial begin
    n_vec = 0; n_err = 0; sel_g = 0;
    prev_s[0] = 16'h0; prev_s[1] = 16'h0;
    rst = 1'b1;
    drive(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    drive(1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_zero(0, "rst16");
    check_zero(1, "rst8");
    rst = 1'b0;

    // Start accepted in the first cycle after reset release
    run_op(0, "add",       16'h1400, 16'h0013, 1'b0, 1'b0, 16'h1413, 1'b0, 1'b0, 1'b0, 0);
    idle_cycle(0, "add");
    run_op(0, "sub_eq",    16'h0014, 16'h0014, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 0);
    idle_cycle(0, "sub_eq");
    run_op(0, "sub_brw",   16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 0);
    idle_cycle(0, "sub_brw");
    run_op(0, "ovf_add",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 0);
    idle_cycle(0, "ovf_add");
    run_op(0, "ovf_sub",   16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 0);
    idle_cycle(0, "ovf_sub");
    run_op(0, "wrap",      16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 0);
    idle_cycle(0, "wrap");
    run_op(0, "cin_prop",  16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 0);
    idle_cycle(0, "cin_prop");
    run_op(0, "inv_noc",   16'h1234, 16'h1111, 1'b0, 1'b1, 16'h0122, 1'b1, 1'b0, 1'b0, 0);
    idle_cycle(0, "inv_noc");

    // Start and operand changes during RUN must not disturb the operation
    run_op(0, "ign_start", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, 2);
    idle_cycle(0, "ign_start");
    idle_cycle(0, "ign_start2");

    // Back-to-back: second start issued in the DONE cycle
    run_op(0, "b2b_1",     16'h0100, 16'h0200, 1'b0, 1'b0, 16'h0300, 1'b0, 1'b0, 1'b0, 0);
    run_op(0, "b2b_2",     16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 0);
    idle_cycle(0, "b2b");

    // Reset in the second RUN cycle aborts without a done pulse
    sel_g = 0;
    drive(0, 1'b1, 16'h0005, 16'h0006, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 16'h0005, 16'h0006, 1'b0, 1'b0);
    check("abort/busy1", 32'(busy16), 32'd1);
    @(posedge clk); #1;
    check("abort/busy2", 32'(busy16), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_zero(0, "abort");
    for (int k = 0; k < 6; k++) idle_cycle(0, "abort_quiet");
    check("abort/s_after", 32'(s16), 32'd0);

    // WIDTH=8, DIGIT=1: eight RUN cycles, done in cycle 9
    run_op(1, "w8_wrap",   16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 0);
    idle_cycle(1, "w8_wrap");
    run_op(1, "w8_ovf",    16'h007F, 16'h0001, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b1, 1'b0, 0);
    run_op(1, "w8_sub",    16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 3);
    idle_cycle(1, "w8_sub");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
